// File: rtl/lm_multi_channel_pkg.sv
// Shared definitions for the multi-channel LED manager: display modes and counter sizing.
package lm_multi_channel_pkg;

  typedef enum logic [1:0] {
    LM_MODE_MANUAL   = 2'b00,
    LM_MODE_ROTATE   = 2'b01,
    LM_MODE_PRIORITY = 2'b10,
    LM_MODE_OFF      = 2'b11
  } lm_mode_e;

  localparam int LM_NUM_CH   = 4;
  localparam int LM_WIDTH_CH = 8;

  // Width of a counter spanning 0..n-1, never narrower than one bit.
  function automatic int lm_cnt_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/lm_multi_channel_channel.sv
// One producer channel: latched status word plus a fresh flag that expires HOLD_CYCLES after the last valid.
module lm_channel
  import lm_multi_channel_pkg::*;
#(
  parameter int WIDTH_CH    = 8,
  parameter int HOLD_CYCLES = 1000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                valid,
  input  logic                clear,
  input  logic [WIDTH_CH-1:0] data,
  output logic [WIDTH_CH-1:0] word,
  output logic                fresh
);
  localparam int HW = lm_cnt_w(HOLD_CYCLES);

  logic [HW-1:0] hold_cnt;

  // A new valid beats a simultaneous clear.
  always_ff @(posedge clk) begin
    if (!rst) begin
      word     <= '0;
      fresh    <= 1'b0;
      hold_cnt <= '0;
    end else if (valid) begin
      word     <= data;
      fresh    <= 1'b1;
      hold_cnt <= HW'(HOLD_CYCLES - 1);
    end else if (clear) begin
      word     <= '0;
      fresh    <= 1'b0;
      hold_cnt <= '0;
    end else if (fresh) begin
      if (hold_cnt == '0) fresh <= 1'b0;
      else                hold_cnt <= hold_cnt - 1'b1;
    end
  end

endmodule

// File: rtl/lm_multi_channel.sv
// LED manager: latches NUM_CH status words and shows one on a shared LED bank (manual/rotate/priority/off).
module lm_multi_channel
  import lm_multi_channel_pkg::*;
#(
  parameter int                NUM_CH        = LM_NUM_CH,
  parameter int                WIDTH_CH      = LM_WIDTH_CH,
  parameter int                SEL_W         = 2,
  parameter int                HOLD_CYCLES   = 1000,
  parameter int                ROTATE_CYCLES = 50000,
  parameter int                BLINK_CYCLES  = 25000,
  parameter logic [NUM_CH-1:0] BLINK_MASK    = NUM_CH'(4'b0110)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_CH*WIDTH_CH-1:0] ch_data,
  input  logic [NUM_CH-1:0]          ch_valid,
  input  logic [1:0]                 mode_sel,
  input  logic [SEL_W-1:0]           ch_sel,
  input  logic                       clear,
  output logic [WIDTH_CH-1:0]        leds,
  output logic [SEL_W-1:0]           active_ch,
  output logic [NUM_CH-1:0]          fresh
);
  localparam int RW = lm_cnt_w(ROTATE_CYCLES);
  localparam int BW = lm_cnt_w(BLINK_CYCLES);

  logic [NUM_CH-1:0][WIDTH_CH-1:0] words;
  lm_mode_e                        mode, mode_q;
  logic                            mode_chg;
  logic [RW-1:0]                   rot_cnt;
  logic                            rot_tc;
  logic [BW-1:0]                   blink_cnt;
  logic                            phase;
  logic                            pri_hit;
  logic [SEL_W-1:0]                pri_idx, next_rot;
  logic [WIDTH_CH-1:0]             shown, leds_d;
  logic                            blink_en;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    lm_channel #(.WIDTH_CH(WIDTH_CH), .HOLD_CYCLES(HOLD_CYCLES)) u_ch (
      .clk   (clk),
      .rst   (rst),
      .valid (ch_valid[g]),
      .clear (clear),
      .data  (ch_data[g*WIDTH_CH +: WIDTH_CH]),
      .word  (words[g]),
      .fresh (fresh[g])
    );
  end

  assign mode     = lm_mode_e'(mode_sel);
  assign mode_chg = (mode != mode_q);
  assign rot_tc   = (rot_cnt == RW'(ROTATE_CYCLES - 1));
  assign next_rot = (active_ch >= SEL_W'(NUM_CH - 1)) ? '0 : active_ch + 1'b1;

  always_comb begin
    pri_hit = 1'b0;
    pri_idx = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (fresh[i]) begin
        pri_hit = 1'b1;
        pri_idx = SEL_W'(i);
      end
    end
  end

  // Out-of-range selections match no channel and therefore show 0.
  always_comb begin
    shown    = '0;
    blink_en = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (active_ch == SEL_W'(i)) begin
        shown    = words[i];
        blink_en = BLINK_MASK[i];
      end
    end
  end

  always_comb begin
    leds_d = shown;
    if (mode == LM_MODE_OFF)                         leds_d = '0;
    else if (blink_en && (shown != '0) && !phase)    leds_d = '0;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      mode_q    <= LM_MODE_MANUAL;
      rot_cnt   <= '0;
      active_ch <= '0;
      blink_cnt <= '0;
      phase     <= 1'b0;
      leds      <= '0;
    end else begin
      mode_q <= mode;
      leds   <= leds_d;

      if (blink_cnt == BW'(BLINK_CYCLES - 1)) begin
        blink_cnt <= '0;
        phase     <= ~phase;
      end else begin
        blink_cnt <= blink_cnt + 1'b1;
      end

      // The rotate dwell restarts on any mode change and is held outside ROTATE.
      if (mode_chg)                      rot_cnt <= '0;
      else if (mode == LM_MODE_ROTATE)   rot_cnt <= rot_tc ? '0 : rot_cnt + 1'b1;

      case (mode)
        LM_MODE_MANUAL:   active_ch <= ch_sel;
        LM_MODE_ROTATE:   if (!mode_chg && rot_tc) active_ch <= next_rot;
        LM_MODE_PRIORITY: if (pri_hit) active_ch <= pri_idx;
        default: ;
      endcase
    end
  end

endmodule
